// File: rtl/gobang_pkg.sv
// Shared definitions for the gobang input front-end.
//   BOARD_N   : default board dimension (cells per side)
//   CUR_W     : width of a cursor coordinate
//   KEY_*     : bit index of each button in the packed key vectors
//   key_state_e : per-key press/auto-repeat state
package gobang_pkg;

    localparam int BOARD_N  = 15;
    localparam int CUR_W    = 4;
    localparam int NUM_KEYS = 5;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_OK    = 4;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } key_state_e;

endpackage

// File: rtl/gobang_key_ctrl_key_edge.sv
// key_edge: one button's path from raw pin to move pulse.
//   2-flop synchroniser -> debouncer (level db) -> press FSM with optional
//   auto-repeat.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   key_raw    : raw button, asynchronous to clk, active high
//   pulse      : registered one-cycle pulse per accepted press / repeat
module key_edge
    import gobang_pkg::*;
#(
    parameter int DEB_CYCLES = 20,
    parameter int REP_DELAY  = 50,
    parameter int REP_RATE   = 10,
    parameter bit REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic pulse
);

    localparam int DEB_W   = $clog2(DEB_CYCLES) + 1;
    localparam int TMR_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    // Terminal counts: the counter value seen on the cycle the event fires.
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] DLY_LAST  = TMR_W'(REP_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST = TMR_W'(REP_RATE - 1);

    logic [1:0]       sync_q, sync_d;
    logic             db_q, db_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    key_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             pulse_q, pulse_d;

    // Synchroniser shift register: key_raw enters at bit 0.
    always_comb begin
        sync_d = {sync_q[0], key_raw};
    end

    // Debouncer: count consecutive cycles the synced level disagrees with db.
    always_comb begin
        db_d      = db_q;
        deb_cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                db_d = ~db_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Press FSM. A release (db low) always returns to IDLE silently.
    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (db_q) begin
                    pulse_d = 1'b1;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (!db_q) begin
                    state_d = IDLE;
                end else if (REPEAT_EN) begin
                    if (tmr_q == DLY_LAST) begin
                        pulse_d = 1'b1;
                        state_d = REPEAT;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (!db_q) begin
                    state_d = IDLE;
                end else if (tmr_q == RATE_LAST) begin
                    pulse_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            db_q      <= 1'b0;
            deb_cnt_q <= '0;
            state_q   <= IDLE;
            tmr_q     <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            db_q      <= db_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/gobang_key_ctrl.sv
// gobang_key_ctrl: five buttons -> clamped board cursor + place strobe.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   key_up/down/left/right/ok : raw buttons (async, active high)
//   en                   : game accepting input; low discards all pulses
//   cur_x, cur_y         : cursor, 0..BOARD_N-1 (y = 0 is top row)
//   place                : one-cycle "put stone at (cur_x,cur_y)" strobe
module gobang_key_ctrl #(
    parameter int DEB_CYCLES = 20,
    parameter int REP_DELAY  = 50,
    parameter int REP_RATE   = 10,
    parameter int BOARD_N    = gobang_pkg::BOARD_N
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         key_up,
    input  logic                         key_down,
    input  logic                         key_left,
    input  logic                         key_right,
    input  logic                         key_ok,
    input  logic                         en,
    output logic [gobang_pkg::CUR_W-1:0] cur_x,
    output logic [gobang_pkg::CUR_W-1:0] cur_y,
    output logic                         place
);

    import gobang_pkg::*;

    localparam logic [CUR_W-1:0] MAX_POS = CUR_W'(BOARD_N - 1);
    localparam logic [CUR_W-1:0] CENTER  = CUR_W'(BOARD_N / 2);

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_pulse;
    logic [CUR_W-1:0]    cur_x_q, cur_x_d;
    logic [CUR_W-1:0]    cur_y_q, cur_y_d;

    assign key_raw = {key_ok, key_right, key_left, key_down, key_up};

    // ok never auto-repeats: holding it must place a single stone.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_edge #(
            .DEB_CYCLES (DEB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_RATE   (REP_RATE),
            .REPEAT_EN  (k != KEY_OK)
        ) u_key_edge (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_raw (key_raw[k]),
            .pulse   (key_pulse[k])
        );
    end

    // Fixed priority up > down > left > right; losing pulses are dropped.
    // A pulse at the board edge is consumed without moving.
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (en) begin
            if (key_pulse[KEY_UP]) begin
                if (cur_y_q != '0) cur_y_d = cur_y_q - 1'b1;
            end else if (key_pulse[KEY_DOWN]) begin
                if (cur_y_q != MAX_POS) cur_y_d = cur_y_q + 1'b1;
            end else if (key_pulse[KEY_LEFT]) begin
                if (cur_x_q != '0) cur_x_d = cur_x_q - 1'b1;
            end else if (key_pulse[KEY_RIGHT]) begin
                if (cur_x_q != MAX_POS) cur_x_d = cur_x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x_q <= CENTER;
            cur_y_q <= CENTER;
        end else begin
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
        end
    end

    assign cur_x = cur_x_q;
    assign cur_y = cur_y_q;
    // The cursor register updates one edge after the pulse, so place always
    // reports the position before any coincident move.
    assign place = key_pulse[KEY_OK] & en;

endmodule

// File: tb/tb_gobang_key_ctrl.sv
module tb_gobang_key_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 5;
    localparam int BN  = 15;
    // Edges after driving a key: first move, first repeat move.
    localparam int MOVE0 = 4 + DEB;
    localparam int MOVE1 = 4 + DEB + RD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_up, key_down, key_left, key_right, key_ok, en;
    logic [3:0] cur_x, cur_y;
    logic       place;

    gobang_key_ctrl #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_RATE   (RR),
        .BOARD_N    (BN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_ok    (key_ok),
        .en        (en),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .place     (place)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int px = 7;
    int py = 7;

    typedef struct {
        int    cyc;
        int    x;
        int    y;
        bit    p;
        string name;
    } exp_t;
    exp_t sb[$];

    // keys vector order: {ok, right, left, down, up}
    typedef struct {
        logic [4:0] keys;
        bit         en;
        bit         p7;
        int         x;
        int         y;
        string      name;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input int ex, input int ey, input bit ep);
        n_chk++;
        if (cur_x !== 4'(ex) || cur_y !== 4'(ey) || place !== ep) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got x=%0d y=%0d place=%0b, want x=%0d y=%0d place=%0b",
                     name, cyc, cur_x, cur_y, place, ex, ey, ep);
        end
    endtask

    task automatic expect_at(input int c, input int x, input int y, input bit p, input string name);
        exp_t e;
        int   i;
        e.cyc = c; e.x = x; e.y = y; e.p = p; e.name = name;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    // Scoreboard: compare expectations due after the edge just passed.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            if (sb[0].cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: expectation for edge %0d missed (now %0d)", sb[0].name, sb[0].cyc, cyc);
            end else begin
                check(sb[0].name, sb[0].x, sb[0].y, sb[0].p);
            end
            void'(sb.pop_front());
        end
    end

    function automatic int clampi(input int v);
        return (v < 0) ? 0 : ((v > BN - 1) ? BN - 1 : v);
    endfunction

    // Number of move pulses consumed by edge e of a continuous hold.
    function automatic int moves_by(input int e);
        int nm;
        nm = 0;
        if (e >= MOVE0) nm = 1;
        if (e >= MOVE1) nm = nm + (e - MOVE1) / RR + 1;
        return nm;
    endfunction

    task automatic sync_edge(output int c0);
        @(posedge clk);
        #1;
        c0 = cyc;
    endtask

    task automatic set_keys(input logic [4:0] k);
        {key_ok, key_right, key_left, key_down, key_up} = k;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a direction continuously; expected cursor at every edge follows the
    // press/repeat schedule with clamping.
    task automatic hold_move(input logic [4:0] k, input int hold, input int dx, input int dy,
                             input string name);
        int c0, ex, ey;
        ex = px; ey = py;
        sync_edge(c0);
        set_keys(k);
        for (int e = 1; e < hold; e++) begin
            ex = clampi(px + dx * moves_by(e));
            ey = clampi(py + dy * moves_by(e));
            expect_at(c0 + e, ex, ey, 1'b0, name);
        end
        repeat (hold) @(posedge clk);
        #1;
        set_keys(5'b0);
        idle(30);
        px = ex;
        py = ey;
    endtask

    initial begin
        int c0, r0;
        vecs[0] = '{5'b01000, 1'b1, 1'b0, 8, 7, "right"};
        vecs[1] = '{5'b01001, 1'b1, 1'b0, 8, 6, "up_right"};
        vecs[2] = '{5'b10000, 1'b0, 1'b0, 8, 6, "ok_dis"};
        vecs[3] = '{5'b10000, 1'b1, 1'b1, 8, 6, "ok_en"};
        vecs[4] = '{5'b10100, 1'b1, 1'b1, 7, 6, "ok_left"};
        vecs[5] = '{5'b00010, 1'b0, 1'b0, 7, 6, "down_dis"};
        vecs[6] = '{5'b01010, 1'b1, 1'b0, 7, 7, "down_right"};
        vecs[7] = '{5'b01100, 1'b1, 1'b0, 6, 7, "left_right"};
        vecs[8] = '{5'b01111, 1'b1, 1'b0, 6, 6, "all_dirs"};

        set_keys(5'b0);
        en    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 7, 7, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // Single presses: registered pulse/place at edge 7, move at edge 8.
        foreach (vecs[i]) begin
            sync_edge(c0);
            set_keys(vecs[i].keys);
            en = vecs[i].en;
            expect_at(c0 + 6, px, py, 1'b0, {vecs[i].name, "@6"});
            expect_at(c0 + 7, px, py, vecs[i].p7, {vecs[i].name, "@7"});
            expect_at(c0 + 8, vecs[i].x, vecs[i].y, 1'b0, {vecs[i].name, "@8"});
            idle(10);
            set_keys(5'b0);
            expect_at(cyc + 20, vecs[i].x, vecs[i].y, 1'b0, {vecs[i].name, "_final"});
            idle(25);
            px = vecs[i].x;
            py = vecs[i].y;
        end
        en = 1'b1;

        // Bouncing up key (2 high / 2 low) never survives the debouncer.
        sync_edge(c0);
        for (int k = 1; k <= 11; k++) expect_at(c0 + 4 * k, px, py, 1'b0, "glitch_up");
        for (int i = 0; i < 20; i++) begin
            key_up = (i % 2 == 0);
            idle(2);
        end
        key_up = 1'b0;
        idle(10);

        // Long holds: repeat schedule and clamping at both board edges.
        hold_move(5'b00100, 100, -1, 0, "hold_left");
        if (px != 0) begin n_chk++; n_fail++; $display("FAIL hold_left_model: x=%0d want 0", px); end
        hold_move(5'b01000, 110, 1, 0, "hold_right");
        hold_move(5'b00001, 70, 0, -1, "hold_up");

        // en raised while down is held: no pulse on raise, next repeat moves.
        sync_edge(c0);
        en = 1'b0;
        set_keys(5'b00010);
        expect_at(c0 + 8,  px, py, 1'b0, "en_raise@8");
        expect_at(c0 + 27, px, py, 1'b0, "en_raise@27");
        expect_at(c0 + 28, px, py + 1, 1'b0, "en_raise@28");
        expect_at(c0 + 32, px, py + 1, 1'b0, "en_raise@32");
        expect_at(c0 + 33, px, py + 2, 1'b0, "en_raise@33");
        expect_at(c0 + 45, px, py + 2, 1'b0, "en_raise@45");
        idle(15);
        en = 1'b1;
        idle(15);
        set_keys(5'b0);
        idle(30);
        py = py + 2;

        // Reset in the middle of a down repeat; key held across release.
        sync_edge(c0);
        set_keys(5'b00010);
        expect_at(c0 + 8,  px, py + 1, 1'b0, "rst_pre@8");
        expect_at(c0 + 33, px, py + 3, 1'b0, "rst_pre@33");
        expect_at(c0 + 38, px, py + 4, 1'b0, "rst_pre@38");
        idle(40);
        rst_n = 1'b0;
        #1;
        check("rst_async", 7, 7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0 = cyc;
        expect_at(r0 + 7,  7, 7, 1'b0, "rst_post@7");
        expect_at(r0 + 8,  7, 8, 1'b0, "rst_post@8");
        expect_at(r0 + 30, 7, 8, 1'b0, "rst_post@30");
        idle(12);
        set_keys(5'b0);
        idle(35);

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gobang_key_ctrl.md
# gobang_key_ctrl

Front-end input controller for the gobang board: takes five raw push-buttons (up, down, left, right, ok), synchronises and debounces each, turns presses into single-cycle pulses with auto-repeat on the direction keys, and sequences them into a clamped 15×15 cursor position plus a one-cycle `place` strobe. Sits between the board pins and the game-logic/VGA blocks, replacing ad-hoc per-key edge detectors with one arbitrated source of moves.

## Interface
- `DEB_CYCLES`, 20: consecutive stable cycles required to accept a level change (≥2).
- `REP_DELAY`, 50: cycles a direction key must be held before the first repeat (≥1).
- `REP_RATE`, 10: cycles between subsequent repeats (≥1).
- `BOARD_N`, 15: board dimension, 2..16.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_up`, `key_down`, `key_left`, `key_right`, `key_ok` in 1 each: raw buttons, active-high, asynchronous to `clk`.
- `en` in 1: game accepting input; low freezes cursor and suppresses `place`.
- `cur_x` out 4: cursor column, 0..BOARD_N-1.
- `cur_y` out 4: cursor row, 0..BOARD_N-1 (0 = top).
- `place` out 1: one-cycle strobe, "put stone at (`cur_x`,`cur_y`)".

## Operation
- Per key: 2-flop synchroniser → debouncer → press-edge detector → repeat timer (repeat on direction keys only; `key_ok` never repeats).
- Debouncer: level `db` (reset 0); counter increments each cycle synchronised input ≠ `db`, clears when equal; on reaching DEB_CYCLES, `db` toggles and counter clears.
- Per-key FSM: IDLE (`db`=0) → on `db` rise emit pulse, go DELAY → after REP_DELAY cycles emit pulse, go REPEAT → pulse every REP_RATE cycles. `db` fall from any state → IDLE, no pulse, timer cleared.
- Arbitration: when several direction pulses coincide, priority up > down > left > right; losers dropped, not queued. `ok` is independent of direction pulses and may coincide with a move.
- Cursor: up decrements `cur_y`, down increments, left decrements `cur_x`, right increments. Clamp at 0 and BOARD_N-1; no wrap. Pulse at an edge is consumed with no change.
- `place` = ok pulse AND `en`. Position reported is the pre-move value when `place` and a move coincide.
- `en`=0: debouncers/FSMs keep running; all pulses discarded. Raising `en` while held does not generate a pulse; the next repeat does.

## Timing
- Reset (async assert, sync-released by the flops): `cur_x`=`cur_y`=BOARD_N/2 (7 for 15), `place`=0, all `db`=0, FSMs IDLE, counters 0.
- Raw key high and stable before edge 0: synchroniser output high after edge 2; `db` rises at edge 2+DEB_CYCLES; pulse/`place` registered high after edge 3+DEB_CYCLES for exactly one cycle; cursor updates at edge 4+DEB_CYCLES.
- Repeats: pulses at 3+DEB_CYCLES+REP_DELAY, then every REP_RATE edges while held.
- Glitches shorter than DEB_CYCLES cycles produce no change in `db`.
- Release: `db` falls DEB_CYCLES+2 edges after stable low; repeat stops at that edge.
- Reset mid-press: all state cleared; key still held at release of reset is debounced afresh and yields one press pulse.
- Counter widths: $clog2 of the respective parameter +1; no overflow possible.

## Structure
- Package `gobang_pkg`: `BOARD_N`, `CUR_W`=4, key index constants (KEY_UP..KEY_OK), per-key FSM state enum (IDLE, DELAY, REPEAT).
- Sub-module `key_edge`: synchroniser + debouncer + FSM, parameter REPEAT_EN; instantiated five times. Top holds arbiter and cursor registers.

## Test plan
Run with DEB_CYCLES=4, REP_DELAY=20, REP_RATE=5, BOARD_N=15.
- Reset, then hold `key_right` 10 cycles → one pulse, `cur_x` 7→8 at edge 8, `cur_y` stays 7.
- `key_up` toggling every 2 cycles for 40 cycles → `cur_y` stays 7, `place` never high.
- Hold `key_left` 100 cycles → moves at edges 8, 28, 33, 38, … ; `cur_x` clamps at 0, no wrap.
- Press `key_up` and `key_right` same cycle → only `cur_y` 7→6; `cur_x` unchanged.
- `en`=0, press `key_ok` → no `place`; `en`=1, press `key_ok` → `place` high one cycle at edge 7, coordinates (7,7).
- Assert `rst_n`=0 mid-repeat on `key_down` → outputs immediately 7/7/0; key held through release → exactly one fresh move after DEB_CYCLES+4 edges.
